// File: rtl/square_share_arb_pkg.sv
// Shared constants, id-width helper and the tag entry type used by the squaring scheduler.
package square_share_arb_pkg;

  localparam int unsigned NReqDefault   = 4;
  localparam int unsigned DwDefault     = 8;
  localparam int unsigned MulLatDefault = 3;

  // Tag ids are sized for the largest supported requester count (8 lanes).
  localparam int unsigned MaxIdW = 3;

  function automatic int unsigned id_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic              vld;
    logic [MaxIdW-1:0] id;
  } tag_t;

endpackage

// File: rtl/square_share_arb_if.sv
// Requester, multiplier and status signals of the squaring scheduler, grouped for port use.
interface square_share_arb_if
  import square_share_arb_pkg::*;
#(
  parameter int unsigned N_REQ = NReqDefault,
  parameter int unsigned DW    = DwDefault
);
  localparam int unsigned ID_W = id_w(N_REQ);

  logic                en_i;
  logic [N_REQ-1:0]    req_vld_i;
  logic [N_REQ*DW-1:0] req_data_i;
  logic [N_REQ-1:0]    req_rdy_o;
  logic [DW-1:0]       mul_a_o;
  logic [DW-1:0]       mul_b_o;
  logic [2*DW-1:0]     mul_p_i;
  logic [N_REQ-1:0]    res_vld_o;
  logic [ID_W-1:0]     res_id_o;
  logic [2*DW-1:0]     res_data_o;
  logic                busy_o;
  logic [15:0]         issue_cnt_o;

  modport slave (
    input  en_i, req_vld_i, req_data_i, mul_p_i,
    output req_rdy_o, mul_a_o, mul_b_o, res_vld_o, res_id_o, res_data_o, busy_o, issue_cnt_o
  );

  modport master (
    output en_i, req_vld_i, req_data_i, mul_p_i,
    input  req_rdy_o, mul_a_o, mul_b_o, res_vld_o, res_id_o, res_data_o, busy_o, issue_cnt_o
  );

endinterface

// File: rtl/square_share_arb_rr_arbiter.sv
// Round-robin grant: first requesting lane searching upward from last+1; pointer moves on accept.
module rr_arbiter
  import square_share_arb_pkg::*;
#(
  parameter int unsigned N_REQ = NReqDefault,
  localparam int unsigned ID_W = id_w(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_i,
  input  logic             en_i,
  input  logic             accept_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]  idx_o
);

  logic [ID_W-1:0] last_q, last_d;
  logic [ID_W-1:0] pos;
  logic            found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    pos   = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      pos = ID_W'((32'(last_q) + k) % N_REQ);
      // Reset gates the grant so stale valids cannot show through while held in reset.
      if (!found && en_i && rst_n && req_i[pos]) begin
        found      = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = pos;
      end
    end
    last_d = accept_i ? idx_o : last_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= ID_W'(N_REQ - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/square_share_arb.sv
// Shares one external pipelined squaring multiplier among N_REQ lanes; a tag pipeline
// matched to the multiplier latency routes each product back to its requester.
module square_share_arb
  import square_share_arb_pkg::*;
#(
  parameter int unsigned N_REQ   = NReqDefault,
  parameter int unsigned DW      = DwDefault,
  parameter int unsigned MUL_LAT = MulLatDefault
) (
  input logic               clk,
  input logic               rst_n,
  square_share_arb_if.slave bus
);

  localparam int unsigned ID_W = id_w(N_REQ);

  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_idx;
  logic             hs;
  logic [DW-1:0]    opnd_sel;

  logic [DW-1:0]    opnd_q, opnd_d;
  tag_t             tag_q [MUL_LAT+1];
  tag_t             tag_d [MUL_LAT+1];
  logic [N_REQ-1:0] res_vld_q, res_vld_d;
  logic [ID_W-1:0]  res_id_q, res_id_d;
  logic [2*DW-1:0]  res_data_q, res_data_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             busy;

  rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_i   (bus.req_vld_i),
    .en_i    (bus.en_i),
    .accept_i(hs),
    .gnt_o   (gnt),
    .idx_o   (gnt_idx)
  );

  assign hs = |(bus.req_vld_i & gnt);

  always_comb begin
    opnd_sel = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt[i]) opnd_sel = bus.req_data_i[i*DW +: DW];
    end
    opnd_d = hs ? opnd_sel : opnd_q;

    tag_d[0].vld = hs;
    tag_d[0].id  = hs ? MaxIdW'(gnt_idx) : tag_q[0].id;
    for (int unsigned k = 1; k <= MUL_LAT; k++) begin
      tag_d[k] = tag_q[k-1];
    end

    // tag_q[MUL_LAT] lines up with the product currently on mul_p_i.
    res_vld_d = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      res_vld_d[i] = tag_q[MUL_LAT].vld && (tag_q[MUL_LAT].id == MaxIdW'(i));
    end
    res_id_d   = tag_q[MUL_LAT].vld ? ID_W'(tag_q[MUL_LAT].id) : res_id_q;
    res_data_d = tag_q[MUL_LAT].vld ? bus.mul_p_i : res_data_q;

    cnt_d = cnt_q + 16'(hs);

    busy = |res_vld_q;
    for (int unsigned k = 0; k <= MUL_LAT; k++) begin
      busy = busy | tag_q[k].vld;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opnd_q     <= '0;
      res_vld_q  <= '0;
      res_id_q   <= '0;
      res_data_q <= '0;
      cnt_q      <= '0;
      for (int unsigned k = 0; k <= MUL_LAT; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      opnd_q     <= opnd_d;
      res_vld_q  <= res_vld_d;
      res_id_q   <= res_id_d;
      res_data_q <= res_data_d;
      cnt_q      <= cnt_d;
      for (int unsigned k = 0; k <= MUL_LAT; k++) begin
        tag_q[k] <= tag_d[k];
      end
    end
  end

  assign bus.req_rdy_o   = gnt;
  assign bus.mul_a_o     = opnd_q;
  assign bus.mul_b_o     = opnd_q;
  assign bus.res_vld_o   = res_vld_q;
  assign bus.res_id_o    = res_id_q;
  assign bus.res_data_o  = res_data_q;
  assign bus.busy_o      = busy;
  assign bus.issue_cnt_o = cnt_q;

endmodule

// File: doc/square_share_arb.md
# square_share_arb

Round-robin scheduler that shares one pipelined 8-bit squaring multiplier among `N_REQ` requesters.

- Accepts operands through per-lane valid/ready handshakes.
- Issues at most one operand per cycle to the multiplier.
- Tracks each in-flight operation's requester ID through a tag pipeline matched to the multiplier latency.
- Returns the 16-bit square to the originating lane with a one-cycle valid pulse.
- Sits between the requesting processing blocks and the multiplier instance, which stays outside this block.

## Interface

Parameters:
- `N_REQ`, default 4: number of requesters, range 2..8.
- `DW`, default 8: operand width. The result is 2*DW.
- `MUL_LAT`, default 3: multiplier latency. If an operand is on `mul_a_o` in cycle c, `mul_p_i` holds its square in cycle c+MUL_LAT. Minimum 1.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `en_i`  in  1: grant enable. While low, no new requests are accepted; in-flight operations still complete.
- `req_vld_i`  in  N_REQ: per-lane request valid.
- `req_data_i`  in  N_REQ*DW: lane i operand at bits [i*DW +: DW].
- `req_rdy_o`  out  N_REQ: one-hot-or-zero grant. Lane i handshakes when `req_vld_i[i] & req_rdy_o[i]`.
- `mul_a_o`  out  DW: registered operand to the multiplier A input.
- `mul_b_o`  out  DW: identical to `mul_a_o`, driven to the multiplier B input.
- `mul_p_i`  in  2*DW: multiplier product.
- `res_vld_o`  out  N_REQ: one-hot result pulse identifying the destination lane.
- `res_id_o`  out  clog2(N_REQ): binary index of the destination lane.
- `res_data_o`  out  2*DW: registered square.
- `busy_o`  out  1: high while any operation is in flight or a result is being presented.
- `issue_cnt_o`  out  16: count of accepted requests, wraps modulo 2^16.

## Operation

Arbitration:
- `req_rdy_o` is combinational from `req_vld_i`, `en_i` and the round-robin pointer `last`.
- When `en_i` is high, `req_rdy_o` selects the first lane with its valid set, searching from `last+1` upward modulo N_REQ.
- When `en_i` is low, `req_rdy_o` is 0.
- Requesters must not make `req_vld_i` depend on `req_rdy_o`.
- A requester holds its valid and data stable until its handshake.
- `last` updates to the granted index only on a handshake. Reset value is N_REQ-1, so lane 0 has first priority.

Issue:
- On a handshake, the operand register (`mul_a_o`/`mul_b_o`) loads that lane's data.
- A tag shift register, depth MUL_LAT+1 with entries {vld, id}, shifts in {1, grant index}.
- With no handshake, it shifts in {0, id unchanged}, and the operand register holds its value.

Return:
- When the tag entry aligned with `mul_p_i` (MUL_LAT stages after issue) is valid:
  - `res_data_o` loads `mul_p_i`;
  - `res_id_o` loads the tag id;
  - `res_vld_o` pulses for one cycle on that lane.
- Otherwise `res_vld_o` is 0, and `res_data_o`/`res_id_o` hold their last values.
- There is no result backpressure. Requesters must accept a result in its pulse cycle.

Status:
- `busy_o` is the OR of all tag valid bits and `res_vld_o`.
- `issue_cnt_o` increments by 1 on each handshake and wraps from 0xFFFF to 0.

Boundary conditions:
- All lanes valid continuously: grants go 0,1,…,N_REQ-1,0,… with one per cycle and no bubbles.
- `en_i` falls mid-stream: no grant in that cycle. Tags already issued still return.
- `en_i` and a handshake in the same cycle: `req_rdy_o` is already 0, so no handshake occurs.
- Reset mid-operation: all tag valids, `res_vld_o`, the operand register and `issue_cnt_o` clear immediately. In-flight results are discarded and never pulsed.

Reset values:
- `req_rdy_o` = 0 (because `req_vld_i` is ignored while in reset).
- `mul_a_o` = 0, `mul_b_o` = 0.
- `res_vld_o` = 0, `res_id_o` = 0, `res_data_o` = 0.
- `busy_o` = 0, `issue_cnt_o` = 0.
- `last` = N_REQ-1.

## Timing

- A handshake in cycle h puts the operand on `mul_a_o` in cycle h+1.
- The product is on `mul_p_i` in cycle h+1+MUL_LAT.
- `res_vld_o` pulses in cycle h+2+MUL_LAT, which is h+5 at the defaults.
- Sustained throughput is one result per cycle.
- Results return in issue order.
- The `req_rdy_o` path is combinational and is the only combinational output. All other outputs are registered.

## Structure

- Shared package holds:
  - the default `N_REQ`/`DW`/`MUL_LAT` constants;
  - the `ID_W = clog2(N_REQ)` function;
  - the tag entry typedef {vld, id}.
- Natural sub-module: `rr_arbiter`. It takes parameter N_REQ, inputs req/en/accept, outputs one-hot grant and binary index, and holds the `last` pointer internally.
- The tag pipeline, operand register, result register and counter live in the top module.
- The multiplier is instantiated by the parent, not inside this block. The bench models it as a MUL_LAT-stage registered square.

## Test plan

1. Lane 0 sends operand 4 in cycle h, all others idle → `res_vld_o` = 0001, `res_id_o` = 0, `res_data_o` = 16 in cycle h+5. `busy_o` is high from h+1 through h+5.
2. All four lanes valid with data 1,2,3,4 from the same cycle → grants 0,1,2,3 on consecutive cycles. Results 1,4,9,16 pulse on lanes 0,1,2,3 in four consecutive cycles. `issue_cnt_o` = 4.
3. Lanes 0 and 2 valid continuously with data 255 → grants alternate 0,2,0,2. Every result is 0xFE01, and `res_id_o` alternates 0,2.
4. `en_i` held low while lane 1 is valid → `req_rdy_o` stays 0. Then raise `en_i` → grant next cycle, result 5 cycles after the handshake.
5. Issue 3 requests, then assert `rst_n` = 0 for one cycle before any result → no `res_vld_o` pulses afterwards. All outputs are at reset values, and the next request is granted to lane 0 first.
6. Preload `issue_cnt_o` to 0xFFFE by issuing 65534 requests, then 2 more → the counter reads 0xFFFF, then 0x0000.
